cpu_mon_multi: RTL
==================

Name: cpu_mon_multi

Overview:
- Parametrised successor to the single-window CPU execution monitor in the tk1 core.
- Monitors the CPU bus against NUM_REGIONS independently configured address windows; each window has its own protect mask for instruction fetch, data read and data write.
- Asserts force_trap to the CPU on a violation, latches fault information and counts violations.
- Sits beside the tk1 core on the same 8-bit-address register bus.

Parameters:
- NUM_REGIONS, 4, number of monitored windows; legal range 1..8.
- CTR_WIDTH, 16, violation counter width; legal range 1..32.
- STICKY_FAULT, 1, 1: once faulted, force_trap stays high until reset. 0: force_trap only on violating cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_valid  in  1  CPU bus access valid
- cpu_instr  in  1  access is an instruction fetch
- cpu_wstrb  in  4  byte write strobes; nonzero = data write
- cpu_addr  in  32  CPU access address
- force_trap  out  1  trap request to CPU
- fault  out  1  fault_pending flag
- cs  in  1  register chip select
- we  in  1  register write enable
- address  in  8  register word address
- write_data  in  32  register write data
- read_data  out  32  register read data
- ready  out  1  register access ready

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Every register updates on posedge clk only.
- ready = cs, combinational, same cycle. read_data is combinational and is 0 when cs=0, when we=1, or for an unmapped address.
- Register map:
  - 0x00 CTRL: write bit0=1 arms the monitor.
  - 0x01 STATUS: read {29'h0, fault_pending, armed, faulted_state}. Writing bit2=1 clears fault_pending only when STICKY_FAULT=0.
  - 0x02 FAULT_ADDR: read only.
  - 0x03 FAULT_INFO: read only; {24'h0, type[1:0], 3'h0, region[2:0]}; type 0=fetch, 1=read, 2=write.
  - 0x04 VIOL_CNT: read only; zero-extended to 32 bits.
  - 0x10+4i FIRST_i, 0x11+4i LAST_i, 0x12+4i MODE_i (bits[2:0] = {write_prot, read_prot, exec_prot}), for i < NUM_REGIONS. Addresses for i ≥ NUM_REGIONS are unmapped.
- Reset values: state DISARMED; all FIRST, LAST, MODE, FAULT_ADDR, FAULT_INFO and VIOL_CNT = 0; fault_pending = 0; force_trap = 0; fault = 0.
- State machine states: DISARMED, ARMED, FAULTED.
  - DISARMED: region registers are writable; no trapping. A CTRL write with bit0=1 moves to ARMED on the next edge.
  - ARMED: region writes are ignored and CTRL writes are ignored. There is no path back to DISARMED except reset.
  - A violation in ARMED moves to FAULTED.
  - FAULTED: monitoring continues. With STICKY_FAULT=1, force_trap = 1 on every cycle. With STICKY_FAULT=0, force_trap is asserted only on violating cycles, and clearing fault_pending returns the state to ARMED.
- Violation:
  - Conditions: cpu_valid=1, state ≠ DISARMED, and for some region i: FIRST_i ≤ cpu_addr ≤ LAST_i (unsigned, inclusive), with the access class enabled in MODE_i.
  - Access class: fetch if cpu_instr=1; write if cpu_instr=0 and cpu_wstrb≠0; read otherwise.
  - A region with FIRST_i > LAST_i never matches.
- force_trap is combinational: it asserts in the same cycle as the violating access.
- Fault capture happens at the edge that ends a violating cycle:
  - If fault_pending=0: latch FAULT_ADDR = cpu_addr and FAULT_INFO = class plus the lowest matching region index, then set fault_pending.
  - If fault_pending=1, FAULT_ADDR and FAULT_INFO are preserved; only the first fault is kept.
- VIOL_CNT increments by 1 for each violating cycle and saturates at 2^CTR_WIDTH−1.
- If a violation and a STATUS clear write occur in the same cycle, the violation wins: fault_pending stays 1, and the fault data is not overwritten.
- Reset asserted mid-operation (including while faulted) returns everything to the reset values on the next edge.

Test Plan:
- Reset, then read 0x00..0x04 and 0x10..0x1F -> all read 0, force_trap=0, ready tracks cs.
- DISARMED: FIRST_0=0x4000_0000, LAST_0=0x4000_00FF, MODE_0=1, then fetch at 0x4000_0010 -> no trap. Arm, then the same fetch -> force_trap=1 in that cycle; FAULT_ADDR=0x4000_0010; FAULT_INFO=0x00; VIOL_CNT=1; STATUS=0x7.
- Armed: write FIRST_0=0 -> readback is unchanged, 0x4000_0000.
- Regions 1 and 2 both cover 0x8000_0000 with write_prot set; write with cpu_wstrb=0xF -> FAULT_INFO=0x81 (type 2, region 1). A read at the same address with read_prot clear -> no trap.
- FIRST_3=0x100, LAST_3=0x0FF, all prot bits set -> no access in 0x0..0xFFFF_FFFF traps on region 3.
- STICKY_FAULT=0, CTR_WIDTH=2: five violations -> VIOL_CNT=3 (saturated). Clear STATUS -> state returns to ARMED, fault_pending=0, force_trap=0 on an idle bus. Assert reset while faulted -> all registers return to 0 on the next edge.

Source files
------------

// File: rtl/cpu_mon_multi.sv
// Multi-window CPU execution monitor: traps fetch/read/write accesses that hit
// protected address windows, records the first fault and counts every violation.
module cpu_mon_multi #(
    parameter int NUM_REGIONS  = 4,
    parameter int CTR_WIDTH    = 16,
    parameter bit STICKY_FAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    output logic        force_trap,
    output logic        fault,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    localparam logic [7:0] ADDR_CTRL        = 8'h00;
    localparam logic [7:0] ADDR_STATUS      = 8'h01;
    localparam logic [7:0] ADDR_FAULT_ADDR  = 8'h02;
    localparam logic [7:0] ADDR_FAULT_INFO  = 8'h03;
    localparam logic [7:0] ADDR_VIOL_CNT    = 8'h04;
    localparam logic [7:0] ADDR_REGION_BASE = 8'h10;
    localparam logic [7:0] ADDR_REGION_END  = 8'(16 + 4 * NUM_REGIONS);

    localparam logic [1:0] CLASS_FETCH = 2'd0;
    localparam logic [1:0] CLASS_READ  = 2'd1;
    localparam logic [1:0] CLASS_WRITE = 2'd2;

    localparam logic [CTR_WIDTH-1:0] CNT_MAX = {CTR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAULTED  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]          first_reg [NUM_REGIONS];
    logic [31:0]          last_reg  [NUM_REGIONS];
    logic [2:0]           mode_reg  [NUM_REGIONS];
    logic [31:0]          fault_addr_reg;
    logic [1:0]           fault_type_reg;
    logic [2:0]           fault_region_reg;
    logic [CTR_WIDTH-1:0] viol_cnt_reg;
    logic                 fault_pending_reg;

    logic                   reg_wr;
    logic                   reg_rd;
    logic                   region_space;
    logic [4:0]             region_off;
    logic [2:0]             region_sel;
    logic [1:0]             region_field;
    logic                   region_wr;
    logic                   arm_req;
    logic                   status_clear;
    logic [1:0]             acc_class;
    logic [NUM_REGIONS-1:0] region_hit;
    logic [2:0]             hit_idx;
    logic                   violation;
    logic                   armed;
    logic                   faulted_state;

    // ------------------------------------------------------------------
    // Register bus decode
    // ------------------------------------------------------------------
    assign ready  = cs;
    assign reg_wr = cs && we;
    assign reg_rd = cs && !we;

    // Region space starts at 0x10; the 5-bit offset wraps 0x20..0x2F onto 0x10..0x1F.
    assign region_space = (address >= ADDR_REGION_BASE) && (address < ADDR_REGION_END);
    assign region_off   = address[4:0] - 5'h10;
    assign region_sel   = region_off[4:2];
    assign region_field = region_off[1:0];

    assign region_wr    = reg_wr && region_space && (state_reg == DISARMED);
    assign arm_req      = reg_wr && (address == ADDR_CTRL) && write_data[0];
    assign status_clear = !STICKY_FAULT && reg_wr && (address == ADDR_STATUS) && write_data[2];

    assign armed         = (state_reg != DISARMED);
    assign faulted_state = (state_reg == FAULTED);
    assign fault         = fault_pending_reg;

    // ------------------------------------------------------------------
    // Access classification and window matching
    // ------------------------------------------------------------------
    always_comb begin
        if (cpu_instr) begin
            acc_class = CLASS_FETCH;
        end else if (|cpu_wstrb) begin
            acc_class = CLASS_WRITE;
        end else begin
            acc_class = CLASS_READ;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_match
            logic in_range;
            logic class_en;

            // An inverted window (first > last) can never satisfy both bounds.
            assign in_range = (cpu_addr >= first_reg[gi]) && (cpu_addr <= last_reg[gi]);
            assign class_en = (acc_class == CLASS_FETCH) ? mode_reg[gi][0] :
                              (acc_class == CLASS_READ)  ? mode_reg[gi][1] :
                                                           mode_reg[gi][2];
            assign region_hit[gi] = in_range && class_en;
        end
    endgenerate

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_hit[i]) begin
                hit_idx = 3'(i);
            end
        end
    end

    assign violation  = cpu_valid && armed && (|region_hit);
    assign force_trap = violation || (STICKY_FAULT && faulted_state);

    // ------------------------------------------------------------------
    // Monitor state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DISARMED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DISARMED: begin
                if (arm_req) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (violation) begin
                    state_next = FAULTED;
                end
            end
            FAULTED: begin
                // A violation in the same cycle as the clear keeps the fault.
                if (status_clear && !violation) begin
                    state_next = ARMED;
                end
            end
            default: state_next = DISARMED;
        endcase
    end

    // ------------------------------------------------------------------
    // Window configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                first_reg[i] <= '0;
                last_reg[i]  <= '0;
                mode_reg[i]  <= '0;
            end
        end else if (region_wr) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (region_sel == 3'(i)) begin
                    case (region_field)
                        2'd0:    first_reg[i] <= write_data;
                        2'd1:    last_reg[i]  <= write_data;
                        2'd2:    mode_reg[i]  <= write_data[2:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault capture and violation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_pending_reg <= 1'b0;
            fault_addr_reg    <= '0;
            fault_type_reg    <= '0;
            fault_region_reg  <= '0;
            viol_cnt_reg      <= '0;
        end else begin
            if (violation) begin
                fault_pending_reg <= 1'b1;
                if (!fault_pending_reg) begin
                    fault_addr_reg   <= cpu_addr;
                    fault_type_reg   <= acc_class;
                    fault_region_reg <= hit_idx;
                end
                if (viol_cnt_reg != CNT_MAX) begin
                    viol_cnt_reg <= viol_cnt_reg + CTR_WIDTH'(1);
                end
            end else if (status_clear) begin
                fault_pending_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register read mux
    // ------------------------------------------------------------------
    always_comb begin
        read_data = '0;
        if (reg_rd) begin
            if (region_space) begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (region_sel == 3'(i)) begin
                        case (region_field)
                            2'd0:    read_data = first_reg[i];
                            2'd1:    read_data = last_reg[i];
                            2'd2:    read_data = {29'h0, mode_reg[i]};
                            default: read_data = '0;
                        endcase
                    end
                end
            end else begin
                case (address)
                    ADDR_STATUS:     read_data = {29'h0, fault_pending_reg, armed, faulted_state};
                    ADDR_FAULT_ADDR: read_data = fault_addr_reg;
                    ADDR_FAULT_INFO: read_data = {24'h0, fault_type_reg, 3'h0, fault_region_reg};
                    ADDR_VIOL_CNT:   read_data = 32'(viol_cnt_reg);
                    default:         read_data = '0;
                endcase
            end
        end
    end

endmodule
